load_buffer: RTL and testbench
==============================

Name: load_buffer

Overview:
- Sits downstream of the reservation station's address-unit path and upstream of the CDB.
- Queues up to DEPTH loads that already have an effective address, and executes them in order against the byte-serial memory controller port.
- Sign- or zero-extends each result and broadcasts it on the CDB load lane.
- Drives the ready signal the reservation station checks before issuing a load.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
ID_WIDTH, 32, data/address width
ROB_WIDTH, 4, ROB tag width; tag 0 means "none"
OP_WIDTH, 6, instruction-type code width (shared constant header)

Ports:
clk_in  in  1  clock, rising edge
rst_n_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; when 0 all state holds and outputs keep their values
rob_lbuffer_rst_in  in  1  misprediction flush
addrunit_lbuffer_en_in  in  1  push valid
addrunit_lbuffer_addr_in  in  ID_WIDTH  effective address
addrunit_lbuffer_dest_in  in  ROB_WIDTH  ROB tag of the load
addrunit_lbuffer_opcode_in  in  OP_WIDTH  LB/LH/LW/LBU/LHU code
lbuffer_rs_rdy_out  out  1  space available for one more load
lbuffer_mem_req_out  out  1  byte read request
lbuffer_mem_addr_out  out  ID_WIDTH  byte address
mem_lbuffer_ack_in  in  1  requested byte returned this cycle
mem_lbuffer_data_in  in  8  returned byte
cdb_lbuffer_b_out  out  ROB_WIDTH  broadcast tag, 0 = no broadcast
cdb_lbuffer_result_out  out  ID_WIDTH  broadcast value

Behaviour:
- Reset (rst_n_in low, async): queue empty, head=tail=count=0, FSM IDLE. lbuffer_mem_req_out=0, lbuffer_mem_addr_out=0, cdb_lbuffer_b_out=0, cdb_lbuffer_result_out=0, lbuffer_rs_rdy_out=1.
- Push: on a rising edge with rdy_in=1, en=1 and no flush, the entry {addr, dest, opcode} is written at tail, and tail advances (mod DEPTH).
  - A push while count==DEPTH is dropped and is a simulation assertion failure.
  - A push with an opcode outside LB..LHU is dropped.
- lbuffer_rs_rdy_out = (count <= DEPTH-2). This is combinational from the count register. The one-slot margin covers the reservation station's registered issue.
- FSM states: IDLE, REQ, DONE.
  - IDLE -> REQ when count>0. Load the head entry, set byte index k=0, set nbytes (LB/LBU=1, LH/LHU=2, LW=4), and clear the assembly register.
  - REQ: req_out=1, addr_out = head.addr + k (wraps mod 2^ID_WIDTH). On ack, store the byte at bits [8k+7:8k] (little-endian) and increment k. If k+1==nbytes -> DONE; otherwise stay in REQ with the next address on the following cycle.
  - DONE: drive cdb_lbuffer_b_out=head.dest for exactly one cycle. cdb_lbuffer_result_out is the sign-extended value (LB, LH) or zero-extended value (LBU, LHU, LW). Pop head, req_out=0, go to IDLE.
- The next load starts no earlier than the cycle after DONE.
- CDB outputs are 0 on every cycle that is not DONE.
- Minimum latency for LB, from a push at edge T with an idle, empty queue:
  - request visible after edge T+1;
  - zero-wait ack at edge T+2;
  - broadcast visible after edge T+3.
- Push and pop on the same edge: count unchanged.
- An ack while req_out=0 is ignored.
- Flush (rob_lbuffer_rst_in=1 with rdy_in=1) on an edge:
  - queue emptied, FSM IDLE, req_out=0, CDB tag 0;
  - any push on that edge is discarded;
  - an ack on the flush edge is ignored.
  - The memory controller is required to abandon a request once req_out drops.
- rdy_in=0: no push, no FSM advance, ack ignored. Outputs hold their values, including a pending DONE broadcast, which fires once rdy_in returns.

Optional Feature:
- Macro: LBUFFER_IO_GUARD_EN.
- Defined:
  - Adds input rob_lbuffer_head_in (ROB_WIDTH), the tag at the ROB head.
  - A head entry with addr[17:16]==2'b11 (the I/O region) stays in IDLE until head.dest == rob_lbuffer_head_in, so I/O reads are never speculative.
  - A flush while waiting empties the queue as normal.
- Undefined: the port is absent and all loads issue immediately in queue order.

Test Plan:
- Push LB addr=0x100 dest=3; memory returns 0x80 with zero wait -> broadcast tag=3, result=0xFFFFFF80, exactly one cycle, 3 edges after the push edge.
- Push LW addr=0x200 dest=5; bytes 0x11,0x22,0x33,0x44 with 1-cycle waits -> addresses 0x200..0x203 in order, result=0x44332211.
- Push LHU 0x10 (0xFF,0xFF) then LH 0x20 (0xFF,0x7F) back-to-back -> tags in push order; results 0x0000FFFF then 0x00007FFF.
- Fill DEPTH=4 with no ack -> lbuffer_rs_rdy_out falls when count reaches 3. Ack all bytes -> rdy_out rises again when count drops back to 2.
- Flush mid-LW after 2 acks with 2 more entries queued -> req_out=0 next cycle, no broadcast, count=0, rdy_out=1. A late ack is ignored.
- With LBUFFER_IO_GUARD_EN: LB addr=0x30000 dest=7, head=2 -> no request. Set head=7 -> request issues on the next cycle.

Source files
------------

// File: rtl/load_buffer.sv
// In-order load queue: byte-serial memory reads, sign/zero extension, CDB load-lane broadcast.
// Build option LBUFFER_IO_GUARD_EN holds I/O-region loads until their tag reaches the ROB head.
module load_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ID_WIDTH  = 32,
    parameter int unsigned ROB_WIDTH = 4,
    parameter int unsigned OP_WIDTH  = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 rob_lbuffer_rst_in,
`ifdef LBUFFER_IO_GUARD_EN
    input  logic [ROB_WIDTH-1:0] rob_lbuffer_head_in,
`endif
    input  logic                 addrunit_lbuffer_en_in,
    input  logic [ID_WIDTH-1:0]  addrunit_lbuffer_addr_in,
    input  logic [ROB_WIDTH-1:0] addrunit_lbuffer_dest_in,
    input  logic [OP_WIDTH-1:0]  addrunit_lbuffer_opcode_in,
    output logic                 lbuffer_rs_rdy_out,
    output logic                 lbuffer_mem_req_out,
    output logic [ID_WIDTH-1:0]  lbuffer_mem_addr_out,
    input  logic                 mem_lbuffer_ack_in,
    input  logic [7:0]           mem_lbuffer_data_in,
    output logic [ROB_WIDTH-1:0] cdb_lbuffer_b_out,
    output logic [ID_WIDTH-1:0]  cdb_lbuffer_result_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Load opcodes form one contiguous range LB..LHU
    localparam logic [OP_WIDTH-1:0] OP_LB  = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_LH  = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_LW  = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_LBU = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_LHU = OP_WIDTH'(15);

    typedef struct packed {
        logic [ID_WIDTH-1:0]  addr;
        logic [ROB_WIDTH-1:0] dest;
        logic [OP_WIDTH-1:0]  op;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    entry_t              q_mem [DEPTH];
    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [CNT_W-1:0]    count_q;
    state_t              state_q;
    entry_t              cur_q;
    logic [1:0]          k_q;
    logic [2:0]          nbytes_q;
    logic [ID_WIDTH-1:0] asm_q;

    entry_t head_c;
    entry_t wr_entry_c;
    logic   op_valid_c;
    logic   full_c;
    logic   push_c;
    logic   pop_c;
    logic   start_ok_c;

    function automatic logic [2:0] nbytes_of(input logic [OP_WIDTH-1:0] op);
        if (op == OP_LB || op == OP_LBU)      return 3'd1;
        else if (op == OP_LH || op == OP_LHU) return 3'd2;
        else                                  return 3'd4;
    endfunction

    function automatic logic [ID_WIDTH-1:0] extend(input logic [OP_WIDTH-1:0] op,
                                                   input logic [ID_WIDTH-1:0] v);
        if (op == OP_LB)      return {{(ID_WIDTH-8){v[7]}}, v[7:0]};
        else if (op == OP_LH) return {{(ID_WIDTH-16){v[15]}}, v[15:0]};
        else                  return v;
    endfunction

    assign head_c     = q_mem[head_q];
    assign wr_entry_c = '{addr: addrunit_lbuffer_addr_in,
                          dest: addrunit_lbuffer_dest_in,
                          op:   addrunit_lbuffer_opcode_in};
    assign op_valid_c = (addrunit_lbuffer_opcode_in >= OP_LB) &&
                        (addrunit_lbuffer_opcode_in <= OP_LHU);
    assign full_c     = (count_q == CNT_W'(DEPTH));
    assign push_c     = rdy_in && addrunit_lbuffer_en_in && !rob_lbuffer_rst_in &&
                        !full_c && op_valid_c;
    assign pop_c      = rdy_in && !rob_lbuffer_rst_in && (state_q == S_DONE);

`ifdef LBUFFER_IO_GUARD_EN
    // I/O-region reads must not be speculative: wait for the ROB head
    assign start_ok_c = (head_c.addr[17:16] != 2'b11) || (head_c.dest == rob_lbuffer_head_in);
`else
    assign start_ok_c = 1'b1;
`endif

    // One free slot of margin absorbs the reservation station's registered issue
    assign lbuffer_rs_rdy_out = (count_q <= CNT_W'(DEPTH - 2));

    always_ff @(posedge clk_in) begin
        if (push_c) q_mem[tail_q] <= wr_entry_c;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q                 <= '0;
            tail_q                 <= '0;
            count_q                <= '0;
            state_q                <= S_IDLE;
            cur_q                  <= '0;
            k_q                    <= '0;
            nbytes_q               <= '0;
            asm_q                  <= '0;
            lbuffer_mem_req_out    <= 1'b0;
            lbuffer_mem_addr_out   <= '0;
            cdb_lbuffer_b_out      <= '0;
            cdb_lbuffer_result_out <= '0;
        end else if (rdy_in) begin
            if (rob_lbuffer_rst_in) begin
                head_q                 <= '0;
                tail_q                 <= '0;
                count_q                <= '0;
                state_q                <= S_IDLE;
                lbuffer_mem_req_out    <= 1'b0;
                cdb_lbuffer_b_out      <= '0;
                cdb_lbuffer_result_out <= '0;
            end else begin
                if (push_c) tail_q <= tail_q + PTR_W'(1);
                if (pop_c)  head_q <= head_q + PTR_W'(1);
                case ({push_c, pop_c})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: ;
                endcase

                cdb_lbuffer_b_out      <= '0;
                cdb_lbuffer_result_out <= '0;

                case (state_q)
                    S_IDLE: begin
                        if (count_q != '0 && start_ok_c) begin
                            cur_q                <= head_c;
                            k_q                  <= '0;
                            nbytes_q             <= nbytes_of(head_c.op);
                            asm_q                <= '0;
                            lbuffer_mem_req_out  <= 1'b1;
                            lbuffer_mem_addr_out <= head_c.addr;
                            state_q              <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (mem_lbuffer_ack_in) begin
                            asm_q[{k_q, 3'b000} +: 8] <= mem_lbuffer_data_in;
                            k_q <= k_q + 2'd1;
                            if (3'(k_q) + 3'd1 == nbytes_q) begin
                                lbuffer_mem_req_out <= 1'b0;
                                state_q             <= S_DONE;
                            end else begin
                                lbuffer_mem_addr_out <= cur_q.addr + ID_WIDTH'(k_q) + ID_WIDTH'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        cdb_lbuffer_b_out      <= cur_q.dest;
                        cdb_lbuffer_result_out <= extend(cur_q.op, asm_q);
                        state_q                <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // A push into a full queue is an upstream protocol violation
    assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(rdy_in && addrunit_lbuffer_en_in && !rob_lbuffer_rst_in && full_c));

endmodule

// File: tb/tb_load_buffer.sv
// Self-checking bench for load_buffer: vector table, scoreboard and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_load_buffer;
    localparam int unsigned DEPTH = 4;
    localparam logic [5:0] OP_LB  = 6'd11;
    localparam logic [5:0] OP_LH  = 6'd12;
    localparam logic [5:0] OP_LW  = 6'd13;
    localparam logic [5:0] OP_LBU = 6'd14;
    localparam logic [5:0] OP_LHU = 6'd15;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush, en;
    logic [31:0] addr_i;
    logic [3:0]  dest_i, head_i;
    logic [5:0]  op_i;
    logic        rs_rdy, req;
    logic [31:0] maddr;
    logic        ack;
    logic [7:0]  mdata;
    logic [3:0]  cdb_b;
    logic [31:0] cdb_res;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [3:0]  dest;
        logic [31:0] bytes;
        int          nbytes;
        int          wait_cyc;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] res;
    } exp_t;

    vec_t        vecs [8];
    exp_t        sb_q [$];
    int          sb_rd = 0;
    logic [7:0]  mem [logic [31:0]];
    logic [31:0] ack_addr [256];
    int          n_ack = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_bcast = 0;
    int          cyc = 0;
    int          push_cyc = 0;
    int          last_bcast_cyc = 0;
    int          wait_cyc = 0;
    int          wcnt = 0;
    logic        resp_en, resp_ack, man_ack;
    logic [7:0]  resp_data, man_data;

    assign ack   = resp_ack | man_ack;
    assign mdata = man_ack ? man_data : resp_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_buffer #(.DEPTH(DEPTH), .ID_WIDTH(32), .ROB_WIDTH(4), .OP_WIDTH(6)) dut (
        .clk_in                     (clk),
        .rst_n_in                   (rst_n),
        .rdy_in                     (rdy),
        .rob_lbuffer_rst_in         (flush),
`ifdef LBUFFER_IO_GUARD_EN
        .rob_lbuffer_head_in        (head_i),
`endif
        .addrunit_lbuffer_en_in     (en),
        .addrunit_lbuffer_addr_in   (addr_i),
        .addrunit_lbuffer_dest_in   (dest_i),
        .addrunit_lbuffer_opcode_in (op_i),
        .lbuffer_rs_rdy_out         (rs_rdy),
        .lbuffer_mem_req_out        (req),
        .lbuffer_mem_addr_out       (maddr),
        .mem_lbuffer_ack_in         (ack),
        .mem_lbuffer_data_in        (mdata),
        .cdb_lbuffer_b_out          (cdb_b),
        .cdb_lbuffer_result_out     (cdb_res)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] a, input logic [3:0] d);
        en = 1'b1; op_i = op; addr_i = a; dest_i = d;
        step();
        push_cyc = cyc;
        en = 1'b0;
    endtask

    task automatic expect_bcast(input logic [3:0] tag, input logic [31:0] res);
        exp_t e;
        e.tag = tag;
        e.res = res;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int t = 0;
        while (sb_q.size() > sb_rd && t < budget) begin
            step();
            t++;
        end
        if (sb_q.size() > sb_rd) check(name, 32'(sb_q.size() - sb_rd), 32'd0);
        step();
    endtask

    // Byte-serial memory model with a programmable wait before each ack
    initial begin
        resp_ack = 1'b0;
        resp_data = 8'h00;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (resp_en && req) begin
                if (wcnt >= wait_cyc) begin
                    resp_ack  = 1'b1;
                    resp_data = mem.exists(maddr) ? mem[maddr] : 8'h00;
                    if (n_ack < 256) ack_addr[n_ack] = maddr;
                    n_ack++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // CDB monitor: every broadcast is compared against the next scoreboard entry
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && cdb_b != 4'd0) begin
                n_bcast++;
                last_bcast_cyc = cyc;
                if (sb_rd >= sb_q.size()) begin
                    check("unexpected_bcast", 32'(cdb_b), 32'd0);
                end else begin
                    check("bcast_tag", 32'(cdb_b), 32'(sb_q[sb_rd].tag));
                    check("bcast_result", cdb_res, sb_q[sb_rd].res);
                    sb_rd++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int nb0;
        int t;
        logic [5:0] bad_ops [3];

        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; en = 1'b0;
        addr_i = '0; dest_i = '0; op_i = '0; head_i = '0;
        man_ack = 1'b0; man_data = 8'h00; resp_en = 1'b1;

        vecs[0] = '{OP_LB,  32'h0000_0100, 4'd3,  32'h0000_0080, 1, 0, 32'hFFFF_FF80};
        vecs[1] = '{OP_LW,  32'h0000_0200, 4'd5,  32'h4433_2211, 4, 1, 32'h4433_2211};
        vecs[2] = '{OP_LHU, 32'h0000_0010, 4'd6,  32'h0000_FFFF, 2, 0, 32'h0000_FFFF};
        vecs[3] = '{OP_LH,  32'h0000_0020, 4'd7,  32'h0000_7FFF, 2, 0, 32'h0000_7FFF};
        vecs[4] = '{OP_LBU, 32'h0000_0040, 4'd8,  32'h0000_0080, 1, 2, 32'h0000_0080};
        vecs[5] = '{OP_LH,  32'h0000_0050, 4'd9,  32'h0000_8000, 2, 1, 32'hFFFF_8000};
        vecs[6] = '{OP_LW,  32'hFFFF_FFFF, 4'd10, 32'h0403_0201, 4, 0, 32'h0403_0201};
        vecs[7] = '{OP_LB,  32'h0000_0060, 4'd15, 32'h0000_007F, 1, 0, 32'h0000_007F};

        step();
        check("rst_req", 32'(req), 32'd0);
        check("rst_addr", maddr, 32'd0);
        check("rst_cdb_tag", 32'(cdb_b), 32'd0);
        check("rst_cdb_result", cdb_res, 32'd0);
        check("rst_rs_rdy", 32'(rs_rdy), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Single loads from the table
        for (int i = 0; i < 8; i++) begin
            int base;
            for (int b = 0; b < vecs[i].nbytes; b++)
                mem[vecs[i].addr + 32'(b)] = vecs[i].bytes[8*b +: 8];
            wait_cyc = vecs[i].wait_cyc;
            base = n_ack;
            expect_bcast(vecs[i].dest, vecs[i].exp);
            push(vecs[i].op, vecs[i].addr, vecs[i].dest);
            wait_drain(200, "vec_drain_timeout");
            check("vec_latency", 32'(last_bcast_cyc - push_cyc),
                  32'(2 + vecs[i].nbytes * (vecs[i].wait_cyc + 1)));
            check("vec_ack_count", 32'(n_ack - base), 32'(vecs[i].nbytes));
            for (int b = 0; b < vecs[i].nbytes; b++)
                check("vec_byte_addr", ack_addr[base + b], vecs[i].addr + 32'(b));
            step();
        end

        // Back-to-back pushes broadcast in push order
        wait_cyc = 0;
        expect_bcast(4'd6, 32'h0000_FFFF);
        expect_bcast(4'd7, 32'h0000_7FFF);
        push(OP_LHU, 32'h10, 4'd6);
        push(OP_LH,  32'h20, 4'd7);
        wait_drain(200, "b2b_drain_timeout");

        // Fill with memory stalled, then drain and watch ready recover
        resp_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem[32'h300 + 32'(i)] = 8'hA0 + 8'(i);
            expect_bcast(4'(i + 1), 32'hFFFF_FFA0 + 32'(i));
            push(OP_LB, 32'h300 + 32'(i), 4'(i + 1));
            check("fill_rs_rdy", 32'(rs_rdy), 32'((i + 1) <= int'(DEPTH - 2)));
        end
        check("fill_req", 32'(req), 32'd1);
        check("fill_addr", maddr, 32'h300);
        resp_en = 1'b1;
        t = 0;
        while (rs_rdy !== 1'b1 && t < 100) begin
            step();
            t++;
        end
        check("refill_rdy", 32'(rs_rdy), 32'd1);
        check("refill_tag", 32'(cdb_b), 32'd2);
        wait_drain(200, "fill_drain_timeout");

        // Flush in the middle of an LW with two more loads queued
        resp_en = 1'b0;
        nb0 = n_bcast;
        push(OP_LW, 32'h400, 4'd11);
        push(OP_LB, 32'h500, 4'd12);
        push(OP_LB, 32'h501, 4'd13);
        check("flush_req_up", 32'(req), 32'd1);
        man_data = 8'h5A; man_ack = 1'b1;
        step();
        step();
        man_ack = 1'b0;
        check("flush_pre_addr", maddr, 32'h402);
        flush = 1'b1; man_ack = 1'b1;
        en = 1'b1; op_i = OP_LB; addr_i = 32'h600; dest_i = 4'd14;
        step();
        flush = 1'b0; man_ack = 1'b0; en = 1'b0;
        check("flush_req", 32'(req), 32'd0);
        check("flush_cdb_tag", 32'(cdb_b), 32'd0);
        check("flush_rs_rdy", 32'(rs_rdy), 32'd1);
        man_ack = 1'b1;
        step();
        step();
        man_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("flush_late_req", 32'(req), 32'd0);
        end
        check("flush_no_bcast", 32'(n_bcast - nb0), 32'd0);
        resp_en = 1'b1;
        expect_bcast(4'd3, 32'hFFFF_FF80);
        push(OP_LB, 32'h100, 4'd3);
        wait_drain(200, "post_flush_timeout");
        check("post_flush_latency", 32'(last_bcast_cyc - push_cyc), 32'd3);

        // Opcodes outside LB..LHU are dropped
        bad_ops[0] = 6'd0; bad_ops[1] = 6'd10; bad_ops[2] = 6'd16;
        for (int i = 0; i < 3; i++) push(bad_ops[i], 32'h100, 4'd9);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bad_op_req", 32'(req), 32'd0);
        end

        // rdy low right after a push stalls the start
        expect_bcast(4'd8, 32'hFFFF_FF80);
        push(OP_LB, 32'h40, 4'd8);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_req", 32'(req), 32'd0);
        end
        rdy = 1'b1;
        wait_drain(200, "hold_drain_timeout");
        check("hold_latency", 32'(last_bcast_cyc - push_cyc), 32'd8);

        // rdy low while the broadcast is pending; it fires when rdy returns
        expect_bcast(4'd4, 32'hFFFF_FF80);
        push(OP_LB, 32'h100, 4'd4);
        step();
        step();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pending_cdb_hold", 32'(cdb_b), 32'd0);
        end
        rdy = 1'b1;
        wait_drain(200, "pending_drain_timeout");
        check("pending_latency", 32'(last_bcast_cyc - push_cyc), 32'd6);

`ifdef LBUFFER_IO_GUARD_EN
        // I/O-region load waits for its tag at the ROB head
        head_i = 4'd2;
        mem[32'h30000] = 8'h7E;
        expect_bcast(4'd7, 32'h0000_007E);
        push(OP_LB, 32'h30000, 4'd7);
        for (int i = 0; i < 4; i++) begin
            step();
            check("io_wait_req", 32'(req), 32'd0);
        end
        head_i = 4'd7;
        step();
        check("io_req", 32'(req), 32'd1);
        check("io_addr", maddr, 32'h30000);
        wait_drain(200, "io_drain_timeout");
`endif

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
